// File: rtl/timer_pkg.sv
// Shared definitions for timer_channels: register word offsets, CTRL/STATUS bit positions
// and the per-channel state type.
package timer_pkg;

  localparam int unsigned RegsPerCh = 8;

  localparam logic [2:0] OffCtrl    = 3'd0;
  localparam logic [2:0] OffLoad    = 3'd1;
  localparam logic [2:0] OffCount   = 3'd2;
  localparam logic [2:0] OffStatus  = 3'd3;
  localparam logic [2:0] OffCapture = 3'd4;

  localparam int unsigned CtrlEnable   = 0;
  localparam int unsigned CtrlPeriodic = 1;
  localparam int unsigned CtrlIrqEn    = 2;

  localparam int unsigned StatExpired  = 0;
  localparam int unsigned StatCaptured = 1;

  typedef enum logic {StIdle, StRun} ch_state_e;

endpackage

// File: rtl/timer_channel.sv
// One down-counting timer channel: IDLE/RUN state, COUNT/LOAD, W1C status and optional capture.
// Capture logic exists only when TIMER_CAPTURE_EN is defined.
module timer_channel
  import timer_pkg::*;
#(
  parameter int unsigned CntW = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            tick_i,
  input  logic            ctrl_we_i,
  input  logic            load_we_i,
  input  logic            status_we_i,
  input  logic [31:0]     wdata_i,
  input  logic            capture_i,
  output logic [2:0]      ctrl_o,
  output logic [CntW-1:0] load_o,
  output logic [CntW-1:0] count_o,
  output logic [CntW-1:0] capture_o,
  output logic [1:0]      status_o,
  output logic            pulse_o,
  output logic            irq_o
);

  ch_state_e       state_q;
  logic            periodic_q, irq_en_q, expired_q, pulse_q;
  logic [CntW-1:0] load_q, count_q;
  logic            stop, expire, clr_expired, captured;

  assign stop        = ctrl_we_i && !wdata_i[CtrlEnable];
  assign expire      = (state_q == StRun) && !stop && tick_i && (count_q == '0);
  assign clr_expired = status_we_i && wdata_i[StatExpired];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      periodic_q <= 1'b0;
      irq_en_q   <= 1'b0;
      expired_q  <= 1'b0;
      pulse_q    <= 1'b0;
      load_q     <= '0;
      count_q    <= '0;
    end else begin
      pulse_q   <= expire;
      // A set event in the same cycle as a W1C keeps the bit set.
      expired_q <= (expired_q & ~clr_expired) | expire;
      if (ctrl_we_i) begin
        periodic_q <= wdata_i[CtrlPeriodic];
        irq_en_q   <= wdata_i[CtrlIrqEn];
      end
      if (load_we_i) load_q <= wdata_i[CntW-1:0];
      case (state_q)
        StIdle: begin
          if (ctrl_we_i && wdata_i[CtrlEnable]) begin
            state_q <= StRun;
            count_q <= load_q;
          end
        end
        StRun: begin
          if (stop) begin
            state_q <= StIdle;
          end else if (tick_i) begin
            if (count_q != '0) count_q <= count_q - CntW'(1);
            else if (periodic_q) count_q <= load_q;
            else state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef TIMER_CAPTURE_EN
  // [0],[1] synchronise capture_i; [2] holds the previous synchronised level for edge detect.
  logic [2:0]      cap_sync_q;
  logic [CntW-1:0] capture_q;
  logic            captured_q, cap_edge, clr_captured;

  assign cap_edge     = cap_sync_q[1] & ~cap_sync_q[2];
  assign clr_captured = status_we_i && wdata_i[StatCaptured];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cap_sync_q <= '0;
      capture_q  <= '0;
      captured_q <= 1'b0;
    end else begin
      cap_sync_q <= {cap_sync_q[1:0], capture_i};
      if (cap_edge) capture_q <= count_q;
      captured_q <= (captured_q & ~clr_captured) | cap_edge;
    end
  end

  assign capture_o = capture_q;
  assign captured  = captured_q;
`else
  logic unused_capture;
  assign unused_capture = capture_i;
  assign capture_o      = '0;
  assign captured       = 1'b0;
`endif

  assign ctrl_o   = {irq_en_q, periodic_q, state_q == StRun};
  assign load_o   = load_q;
  assign count_o  = count_q;
  assign status_o = {captured, expired_q};
  assign pulse_o  = pulse_q;
  assign irq_o    = expired_q & irq_en_q;

endmodule

// File: rtl/timer_channels.sv
// Multi-channel Avalon-MM timer: shared prescaler, N_CH timer_channel instances, decode and read
// mux. Define TIMER_CAPTURE_EN to build the per-channel input-capture logic.
module timer_channels
  import timer_pkg::*;
#(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned PRESC_W = 16,
  localparam int unsigned ADDR_W = $clog2(N_CH * RegsPerCh + 1)
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              irq,
  input  logic [N_CH-1:0]   capture_in,
  output logic [N_CH-1:0]   pulse_out
);

  localparam int unsigned OffW = $clog2(RegsPerCh);
  localparam int unsigned ChW  = ADDR_W - OffW;

  logic [ChW-1:0]  ch_sel;
  logic [OffW-1:0] reg_off;
  logic            presc_sel;

  assign ch_sel    = avs_address[ADDR_W-1:OffW];
  assign reg_off   = avs_address[OffW-1:0];
  assign presc_sel = avs_address == ADDR_W'(N_CH * RegsPerCh);

  logic [PRESC_W-1:0] presc_q, presc_cnt_q;
  logic               tick;

  assign tick = presc_cnt_q == presc_q;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      presc_q     <= '0;
      presc_cnt_q <= '0;
    end else if (avs_write && presc_sel) begin
      presc_q     <= avs_writedata[PRESC_W-1:0];
      presc_cnt_q <= '0;
    end else if (tick) begin
      presc_cnt_q <= '0;
    end else begin
      presc_cnt_q <= presc_cnt_q + PRESC_W'(1);
    end
  end

  logic [2:0]       ch_ctrl    [N_CH];
  logic [CNT_W-1:0] ch_load    [N_CH];
  logic [CNT_W-1:0] ch_count   [N_CH];
  logic [CNT_W-1:0] ch_capture [N_CH];
  logic [1:0]       ch_status  [N_CH];
  logic [N_CH-1:0]  ch_irq;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic ch_hit;
    assign ch_hit = avs_write && (ch_sel == ChW'(c));

    timer_channel #(
      .CntW(CNT_W)
    ) u_ch (
      .clk_i      (clk_clk),
      .reset_i    (reset_reset),
      .tick_i     (tick),
      .ctrl_we_i  (ch_hit && (reg_off == OffCtrl)),
      .load_we_i  (ch_hit && (reg_off == OffLoad)),
      .status_we_i(ch_hit && (reg_off == OffStatus)),
      .wdata_i    (avs_writedata),
      .capture_i  (capture_in[c]),
      .ctrl_o     (ch_ctrl[c]),
      .load_o     (ch_load[c]),
      .count_o    (ch_count[c]),
      .capture_o  (ch_capture[c]),
      .status_o   (ch_status[c]),
      .pulse_o    (pulse_out[c]),
      .irq_o      (ch_irq[c])
    );
  end

  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    if (presc_sel) rdata[PRESC_W-1:0] = presc_q;
    for (int c = 0; c < N_CH; c++) begin
      if (ch_sel == ChW'(c)) begin
        case (reg_off)
          OffCtrl:    rdata[2:0]       = ch_ctrl[c];
          OffLoad:    rdata[CNT_W-1:0] = ch_load[c];
          OffCount:   rdata[CNT_W-1:0] = ch_count[c];
          OffStatus:  rdata[1:0]       = ch_status[c];
          OffCapture: rdata[CNT_W-1:0] = ch_capture[c];
          default:    ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) avs_readdata <= '0;
    else if (avs_read) avs_readdata <= rdata;
  end

  assign irq = |ch_irq;

endmodule
